coin_lane_sequencer: RTL and testbench



---
 rtl/coin_game_pkg.sv | 23 ++
 rtl/sync_rise.sv | 38 +++
 rtl/coin_lane_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_coin_lane_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/coin_game_pkg.sv
// Shared types and constants for the coin lane game-flow controller.
package coin_game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GAP    = 3'd1,
    TRAVEL = 3'd2,
    WINDOW = 3'd3,
    HIT    = 3'd4,
    MISS   = 3'd5,
    OVER   = 3'd6
  } state_t;

  localparam int unsigned LFSR_W        = 8;
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;  // x^8+x^6+x^5+x^4+1
  localparam logic [7:0]  LFSR_ZERO_SUB = 8'h01;
  localparam int unsigned MISS_W        = 4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser; EDGE=1 yields a one-cycle rise pulse, EDGE=0 the synchronised level.
module sync_rise #(
  parameter int unsigned WIDTH = 1,
  parameter bit          EDGE  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q_c
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  generate
    if (EDGE) begin : g_rise
      logic [WIDTH-1:0] r_prev;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= '0;
        else          r_prev <= r_s2;
      end
      assign o_q_c = r_s2 & ~r_prev;
    end else begin : g_level
      assign o_q_c = r_s2;
    end
  endgenerate

endmodule

// File: rtl/coin_lane_sequencer.sv
// Game-flow controller: spawns coins on a pseudo-random lane, judges strikes
// inside a frame-counted window, and keeps score / misses / game-over.
module coin_lane_sequencer
  import coin_game_pkg::*;
#(
  parameter int unsigned N_LANES           = 3,
  parameter int unsigned GAP_FRAMES        = 30,
  parameter int unsigned WINDOW_FRAMES     = 20,
  parameter int unsigned TRAVEL_MAX_FRAMES = 120,
  parameter int unsigned MAX_MISSES        = 3,
  parameter int unsigned SCORE_W           = 16,
  parameter logic [7:0]  LFSR_SEED         = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_v_sync,
  input  logic               i_start,
  input  logic [N_LANES-1:0] i_in_position,
  input  logic [N_LANES-1:0] i_strike,
  output logic [N_LANES-1:0] o_active,
  output logic [SCORE_W-1:0] o_score,
  output logic [MISS_W-1:0]  o_misses,
  output logic               o_game_over,
  output logic [2:0]         o_state
);

  localparam int unsigned LANE_W  = (N_LANES > 2) ? 2 : 1;
  localparam int unsigned CNT_MAX =
    (GAP_FRAMES > WINDOW_FRAMES)
      ? ((GAP_FRAMES > TRAVEL_MAX_FRAMES) ? GAP_FRAMES : TRAVEL_MAX_FRAMES)
      : ((WINDOW_FRAMES > TRAVEL_MAX_FRAMES) ? WINDOW_FRAMES : TRAVEL_MAX_FRAMES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [7:0]  SEED_EFF = (LFSR_SEED == 8'h00) ? LFSR_ZERO_SUB : LFSR_SEED;

  logic               w_tick;
  logic               w_start_rise;
  logic [N_LANES-1:0] w_inpos;
  logic [N_LANES-1:0] w_strike_rise;

  sync_rise #(.WIDTH(1), .EDGE(1'b1)) u_vsync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_v_sync), .o_q_c(w_tick));
  sync_rise #(.WIDTH(1), .EDGE(1'b1)) u_start (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_start), .o_q_c(w_start_rise));
  sync_rise #(.WIDTH(N_LANES), .EDGE(1'b0)) u_inpos (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_in_position), .o_q_c(w_inpos));
  sync_rise #(.WIDTH(N_LANES), .EDGE(1'b1)) u_strike (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_strike), .o_q_c(w_strike_rise));

  state_t             r_state, w_state_nxt;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [LANE_W-1:0]  r_lane, w_lane_nxt;
  logic [N_LANES-1:0] r_active, w_active_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic [MISS_W-1:0]  r_misses, w_misses_nxt;
  logic               r_game_over, w_game_over_nxt;

  logic [LANE_W-1:0]  w_lane_pick;
  logic [N_LANES-1:0] w_lane_mask;
  logic               w_good_strike;
  logic               w_bad_strike;
  logic [MISS_W-1:0]  w_miss_inc;

  // Free-running LFSR; the lane is sampled from it at spawn time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= SEED_EFF;
    else          r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_lane_pick   = LANE_W'(r_lfsr % 8'(N_LANES));
  assign w_lane_mask   = N_LANES'(1) << r_lane;
  assign w_good_strike = |(w_strike_rise & w_lane_mask);
  assign w_bad_strike  = |(w_strike_rise & ~w_lane_mask);
  assign w_miss_inc    = r_misses + MISS_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lane      <= '0;
      r_active    <= '0;
      r_score     <= '0;
      r_misses    <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lane      <= w_lane_nxt;
      r_active    <= w_active_nxt;
      r_score     <= w_score_nxt;
      r_misses    <= w_misses_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  // One shared frame counter serves the gap, travel watchdog and hit window.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lane_nxt      = r_lane;
    w_active_nxt    = r_active;
    w_score_nxt     = r_score;
    w_misses_nxt    = r_misses;
    w_game_over_nxt = r_game_over;
    case (r_state)
      IDLE: begin
        w_active_nxt = '0;
        if (w_start_rise) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = CNT_W'(GAP_FRAMES);
        end
      end
      GAP: begin
        if (w_tick) begin
          if (r_cnt == CNT_W'(1)) begin
            w_lane_nxt   = w_lane_pick;
            w_active_nxt = N_LANES'(1) << w_lane_pick;
            w_cnt_nxt    = CNT_W'(TRAVEL_MAX_FRAMES);
            w_state_nxt  = TRAVEL;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      TRAVEL: begin
        if (w_inpos[r_lane]) begin
          w_state_nxt = WINDOW;
          w_cnt_nxt   = CNT_W'(WINDOW_FRAMES);
        end else if (w_tick) begin
          if (r_cnt == CNT_W'(1)) w_state_nxt = MISS;
          else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      WINDOW: begin
        if (w_bad_strike) begin
          w_state_nxt = MISS;
        end else if (w_good_strike) begin
          w_state_nxt = HIT;
        end else if (w_tick) begin
          if (r_cnt == CNT_W'(1)) w_state_nxt = MISS;
          else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      HIT: begin
        if (r_score != {SCORE_W{1'b1}}) w_score_nxt = r_score + SCORE_W'(1);
        w_active_nxt = '0;
        w_cnt_nxt    = CNT_W'(GAP_FRAMES);
        w_state_nxt  = GAP;
      end
      MISS: begin
        w_misses_nxt = w_miss_inc;
        w_active_nxt = '0;
        if (w_miss_inc == MISS_W'(MAX_MISSES)) begin
          w_state_nxt     = OVER;
          w_game_over_nxt = 1'b1;
        end else begin
          w_state_nxt = GAP;
          w_cnt_nxt   = CNT_W'(GAP_FRAMES);
        end
      end
      OVER: begin
        w_active_nxt    = '0;
        w_game_over_nxt = 1'b1;
        if (w_start_rise) begin
          w_score_nxt     = '0;
          w_misses_nxt    = '0;
          w_game_over_nxt = 1'b0;
          w_cnt_nxt       = CNT_W'(GAP_FRAMES);
          w_state_nxt     = GAP;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_active_nxt = '0;
      end
    endcase
  end

  assign o_active    = r_active;
  assign o_score     = r_score;
  assign o_misses    = r_misses;
  assign o_game_over = r_game_over;
  assign o_state     = r_state;

endmodule

// File: tb/tb_coin_lane_sequencer.sv
// Directed bench for coin_lane_sequencer with a reference LFSR for lane prediction.
module tb_coin_lane_sequencer;

  localparam int ST_IDLE = 0, ST_GAP = 1, ST_TRAVEL = 2, ST_WINDOW = 3, ST_OVER = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_sync;
  logic        start;
  logic [2:0]  in_pos;
  logic [2:0]  strike;
  logic [2:0]  o_active;
  logic [15:0] o_score;
  logic [3:0]  o_misses;
  logic        o_game_over;
  logic [2:0]  o_state;

  int total = 0;
  int bad   = 0;

  coin_lane_sequencer #(
    .N_LANES(3), .GAP_FRAMES(4), .WINDOW_FRAMES(3), .TRAVEL_MAX_FRAMES(10),
    .MAX_MISSES(3), .SCORE_W(16), .LFSR_SEED(8'hA5)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start),
    .i_in_position(in_pos), .i_strike(strike), .o_active(o_active),
    .o_score(o_score), .o_misses(o_misses), .o_game_over(o_game_over),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, one step per clock.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // Spawn monitor: lane chosen from the LFSR value on the cycle before o_active rose.
  int         spawn_cnt = 0;
  int         last_lane = 0;
  logic [2:0] last_exp  = '0;
  logic [2:0] last_obs  = '0;
  logic [2:0] prev_act  = '0;
  always @(negedge clk) begin
    if (rst_n && o_active != 3'b000 && prev_act == 3'b000) begin
      spawn_cnt++;
      last_lane = int'(m_prev % 8'd3);
      last_exp  = 3'b001 << last_lane;
      last_obs  = o_active;
    end
    prev_act = rst_n ? o_active : 3'b000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic frame(input int n);
    repeat (n) begin
      v_sync = 1'b1; step(3);
      v_sync = 1'b0; step(3);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(3);
    start = 1'b0; step(3);
  endtask

  task automatic pulse_strike(input logic [2:0] v);
    strike = v; step(3);
    strike = 3'b000; step(3);
  endtask

  int lane;

  initial begin
    rst_n = 1'b0; v_sync = 1'b0; start = 1'b0; in_pos = '0; strike = '0;
    step(2);
    chk("rst_active", 32'(o_active), 0);
    chk("rst_score", 32'(o_score), 0);
    chk("rst_misses", 32'(o_misses), 0);
    chk("rst_over", 32'(o_game_over), 0);
    chk("rst_state", 32'(o_state), ST_IDLE);
    rst_n = 1'b1;
    step(2);

    frame(2);
    chk("idle_no_start", 32'(o_state), ST_IDLE);
    pulse_start();
    chk("start_gap", 32'(o_state), ST_GAP);
    frame(3);
    chk("gap3_no_active", 32'(o_active), 0);
    chk("gap3_no_spawn", 32'(spawn_cnt), 0);
    frame(1);
    chk("spawn1_cnt", 32'(spawn_cnt), 1);
    chk("spawn1_lane", 32'(last_obs), 32'(last_exp));
    chk("spawn1_travel", 32'(o_state), ST_TRAVEL);

    // Coin reaches position after two frames; correct strike scores
    lane = last_lane;
    frame(2);
    in_pos = 3'b001 << lane;
    step(4);
    chk("hit_window", 32'(o_state), ST_WINDOW);
    pulse_strike(3'b001 << lane);
    in_pos = '0;
    chk("hit_score", 32'(o_score), 1);
    chk("hit_active", 32'(o_active), 0);
    chk("hit_gap", 32'(o_state), ST_GAP);

    // Window expiry
    frame(4);
    chk("spawn2_cnt", 32'(spawn_cnt), 2);
    chk("spawn2_lane", 32'(last_obs), 32'(last_exp));
    lane = last_lane;
    in_pos = 3'b001 << lane;
    step(4);
    frame(2);
    chk("win2_still", 32'(o_state), ST_WINDOW);
    frame(1);
    in_pos = '0;
    chk("exp_misses", 32'(o_misses), 1);
    chk("exp_active", 32'(o_active), 0);
    chk("exp_gap", 32'(o_state), ST_GAP);
    pulse_strike(3'b111);
    chk("gap_strike_score", 32'(o_score), 1);
    frame(3);
    chk("respawn_not_yet", 32'(spawn_cnt), 2);
    frame(1);
    chk("spawn3_cnt", 32'(spawn_cnt), 3);
    chk("spawn3_lane", 32'(last_obs), 32'(last_exp));

    // Correct and wrong lane struck together
    lane = last_lane;
    in_pos = 3'b001 << lane;
    step(4);
    pulse_strike((3'b001 << lane) | (3'b001 << ((lane + 1) % 3)));
    in_pos = '0;
    chk("dual_misses", 32'(o_misses), 2);
    chk("dual_score", 32'(o_score), 1);
    chk("dual_gap", 32'(o_state), ST_GAP);

    // Coin never arrives: watchdog miss, third miss ends the game
    frame(4);
    chk("spawn4_cnt", 32'(spawn_cnt), 4);
    frame(9);
    chk("stuck_travel", 32'(o_state), ST_TRAVEL);
    frame(1);
    chk("over_state", 32'(o_state), ST_OVER);
    chk("over_flag", 32'(o_game_over), 1);
    chk("over_misses", 32'(o_misses), 3);
    chk("over_active", 32'(o_active), 0);
    pulse_strike(3'b010);
    chk("over_strike_score", 32'(o_score), 1);
    pulse_start();
    chk("restart_state", 32'(o_state), ST_GAP);
    chk("restart_score", 32'(o_score), 0);
    chk("restart_misses", 32'(o_misses), 0);
    chk("restart_over", 32'(o_game_over), 0);

    // Saturation at all-ones
    frame(4);
    chk("spawn5_lane", 32'(last_obs), 32'(last_exp));
    lane = last_lane;
    in_pos = 3'b001 << lane;
    step(4);
    force dut.r_score = 16'hFFFF;
    step(1);
    release dut.r_score;
    step(1);
    chk("sat_pre", 32'(o_score), 32'hFFFF);
    pulse_strike(3'b001 << lane);
    in_pos = '0;
    chk("sat_score", 32'(o_score), 32'hFFFF);
    chk("sat_gap", 32'(o_state), ST_GAP);

    // Asynchronous reset mid-window
    frame(4);
    lane = last_lane;
    in_pos = 3'b001 << lane;
    step(4);
    chk("rst2_window", 32'(o_state), ST_WINDOW);
    rst_n = 1'b0;
    #1;
    chk("rst2_active", 32'(o_active), 0);
    chk("rst2_score", 32'(o_score), 0);
    chk("rst2_state", 32'(o_state), ST_IDLE);
    chk("rst2_misses", 32'(o_misses), 0);
    step(2);
    in_pos = '0;
    rst_n = 1'b1;
    frame(2);
    chk("rst2_idle", 32'(o_state), ST_IDLE);
    chk("rst2_idle_active", 32'(o_active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
